// File: rtl/fetch_hazard_ctrl.sv
// Fetch/hazard sequencer for the 5-stage pipeline: load-use stalls, mul/div hold, branch/jump redirect, HALT/resume.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module fetch_hazard_ctrl #(
  parameter int MD_LAT = 4
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic       id_md,
  input  logic       id_branch_taken,
  input  logic       id_jump,
  input  logic       id_halt,
  input  logic       resume,
  output logic [1:0] pcsource,
  output logic       stall,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       halted,
  output logic       busy_md
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
  , output logic [CNT_W-1:0] md_count
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [1:0] PC_PC4 = 2'b00;
  localparam logic [1:0] PC_BPC = 2'b01;
  localparam logic [1:0] PC_JPC = 2'b10;

  // MDWAIT counts MD_LAT-2 down to 0 inclusive, giving MD_LAT-1 stall cycles.
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       loaduse;

  assign loaduse = ex_wreg & ex_m2reg & (ex_rd != 5'd0) &
                   ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    pcsource  = PC_PC4;
    stall     = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    halted    = 1'b0;
    busy_md   = 1'b0;
    case (state_q)
      RUN: begin
        if (loaduse) begin
          stall     = 1'b1;
          bubble_ex = 1'b1;
        end else if (id_halt) begin
          stall     = 1'b1;
          bubble_ex = 1'b1;
          state_d   = HALT;
        end else if (id_md) begin
          state_d  = MDWAIT;
          md_cnt_d = MD_INIT;
        end else if (id_jump) begin
          pcsource = PC_JPC;
          flush_id = 1'b1;
        end else if (id_branch_taken) begin
          pcsource = PC_BPC;
          flush_id = 1'b1;
        end
      end
      MDWAIT: begin
        stall     = 1'b1;
        bubble_ex = 1'b1;
        busy_md   = 1'b1;
        if (md_cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      HALT: begin
        halted    = 1'b1;
        bubble_ex = 1'b1;
        // Resume lets the PC move past the held HALT and turns it into a NOP.
        if (resume) begin
          flush_id = 1'b1;
          state_d  = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [CNT_W-1:0] md_count_q, md_count_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    md_count_d     = md_count_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_id && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
    if ((state_q == RUN) && (state_d == MDWAIT) && (md_count_q != '1))
      md_count_d = md_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      md_count_q     <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      md_count_q     <= md_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign md_count     = md_count_q;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed scoreboard bench for fetch_hazard_ctrl (MD_LAT=4); counter checks run when PERF_CNT_EN is defined.
module tb_fetch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_use_rs = 0, id_use_rt = 0, ex_wreg = 0, ex_m2reg = 0;
  logic       id_md = 0, id_branch_taken = 0, id_jump = 0, id_halt = 0, resume = 0;
  logic [1:0] pcsource;
  logic       stall, flush_id, bubble_ex, halted, busy_md;
`ifdef PERF_CNT_EN
  logic [3:0] stall_cycles, flush_count, md_count;
`endif

  fetch_hazard_ctrl #(
    .MD_LAT(4)
`ifdef PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .id_md(id_md), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .id_halt(id_halt), .resume(resume),
    .pcsource(pcsource), .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .halted(halted), .busy_md(busy_md)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .md_count(md_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected vector layout: {pcsource[1:0], stall, flush_id, bubble_ex, halted, busy_md}
  localparam logic [6:0] E_IDLE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] E_LU   = 7'b00_1_0_1_0_0;
  localparam logic [6:0] E_BR   = 7'b01_0_1_0_0_0;
  localparam logic [6:0] E_JMP  = 7'b10_0_1_0_0_0;
  localparam logic [6:0] E_MDW  = 7'b00_1_0_1_0_1;
  localparam logic [6:0] E_HLT  = 7'b00_1_0_1_1_0;
  localparam logic [6:0] E_RES  = 7'b00_0_1_1_1_0;

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  // lu sets up a load in EX whose rd is compared with rs=5 and rt=9 in ID.
  task automatic cyc(input string nm, input logic [6:0] e, input logic r, input logic lu,
                     input logic [4:0] rd, input logic md, input logic br, input logic jmp,
                     input logic hlt, input logic res);
    @(posedge clk);
    #1;
    clrn            = r;
    ex_wreg         = lu;
    ex_m2reg        = lu;
    ex_rd           = rd;
    id_rs           = 5'd5;
    id_rt           = 5'd9;
    id_use_rs       = lu;
    id_use_rt       = lu;
    id_md           = md;
    id_branch_taken = br;
    id_jump         = jmp;
    id_halt         = hlt;
    resume          = res;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

`ifdef PERF_CNT_EN
  task automatic chk_cnt(input string nm, input logic [3:0] act, input logic [3:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, e);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask
`endif

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e, act;
      string      nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pcsource, stall, flush_id, bubble_ex, halted, busy_md};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s actual=%b required=%b", nm, act, e);
      end else begin
        $display("ok   %s %b", nm, act);
      end
    end
  end

  initial begin
    //   name          expect  rst lu rd     md br jp hl rs
    cyc("reset",       E_IDLE, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("idle",        E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("lu_rs",       E_LU,   0, 1, 5'd5, 0, 0, 0, 0, 0);
    cyc("after_lu",    E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("lu_rd0",      E_IDLE, 0, 1, 5'd0, 0, 0, 0, 0, 0);
    cyc("lu_rt",       E_LU,   0, 1, 5'd9, 0, 0, 0, 0, 0);
    cyc("lu_nomatch",  E_IDLE, 0, 1, 5'd7, 0, 0, 0, 0, 0);
    cyc("md_issue",    E_IDLE, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    cyc("md_w1",       E_MDW,  0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("md_w2_brjmp", E_MDW,  0, 0, 5'd0, 0, 1, 1, 0, 0);
    cyc("md_w3_hlt",   E_MDW,  0, 1, 5'd5, 0, 0, 0, 1, 0);
    cyc("md_done",     E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("branch",      E_BR,   0, 0, 5'd0, 0, 1, 0, 0, 0);
    cyc("jmp_and_br",  E_JMP,  0, 0, 5'd0, 0, 1, 1, 0, 0);
    cyc("jump",        E_JMP,  0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc("br_loaduse",  E_LU,   0, 1, 5'd5, 0, 1, 0, 0, 0);
    cyc("lu_over_hlt", E_LU,   0, 1, 5'd5, 0, 0, 0, 1, 0);
    cyc("no_halt",     E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("halt_enter",  E_LU,   0, 0, 5'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("halt_hold%0d", i), E_HLT, 0, 0, 5'd0, 0, 1, 0, 1, 0);
    cyc("resume",      E_RES,  0, 0, 5'd0, 0, 0, 0, 1, 1);
    cyc("resume_run",  E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 1);
    cyc("md_issue2",   E_IDLE, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    cyc("md_rst",      E_MDW,  1, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("after_mdrst", E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
    @(negedge clk);
    chk_cnt("stall_cycles_rst", stall_cycles, 4'd0);
    chk_cnt("flush_count_rst", flush_count, 4'd0);
    chk_cnt("md_count_rst", md_count, 4'd0);
`endif
    cyc("halt2",       E_LU,   0, 0, 5'd0, 0, 0, 0, 1, 0);
    cyc("halt_rst",    E_HLT,  1, 0, 5'd0, 0, 0, 0, 1, 0);
    cyc("after_hrst",  E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    cyc("halt3",       E_LU,   0, 0, 5'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("sat_hold%0d", i), E_HLT, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    cyc("resume3",     E_RES,  0, 0, 5'd0, 0, 0, 0, 1, 1);
    cyc("final",       E_IDLE, 0, 0, 5'd0, 0, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
    @(negedge clk);
    chk_cnt("stall_cycles_sat", stall_cycles, 4'd15);
    chk_cnt("flush_count", flush_count, 4'd1);
    chk_cnt("md_count", md_count, 4'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
